// File: rtl/chacha_host_driver.sv
// Host-side sequencer for the ChaCha byte-wide chip interface: key/nonce/counter loads and block reads.
// Define CHACHA_HOST_BLKCNT_EN to add the blk_count output (error-free blocks read since reset or LOAD_CTR).
module chacha_host_driver #(
    parameter int KEY_BYTES   = 32,
    parameter int NONCE_BYTES = 8,
    parameter int CTR_BYTES   = 8,
    parameter int BLK_BYTES   = 64,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        err,
`ifdef CHACHA_HOST_BLKCNT_EN
    output logic [31:0] blk_count,
`endif
    output logic [7:0]  chip_data_out,
    output logic        chip_wr_key,
    output logic        chip_wr_nnc,
    output logic        chip_wr_ctr,
    output logic        chip_rd_blk,
    output logic        chip_hold,
    input  logic        chip_blk_ready,
    input  logic [7:0]  chip_data_in
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, READ} state_t;

    localparam logic [1:0] OP_KEY   = 2'd0;
    localparam logic [1:0] OP_NONCE = 2'd1;
    localparam logic [1:0] OP_CTR   = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;
    localparam int         WAIT_W   = $clog2(TIMEOUT) + 1;

    state_t            state, state_next;
    logic [1:0]        op;
    logic [6:0]        byte_cnt;
    logic [6:0]        load_last_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              aborted;
    logic              pend;          // a read strobe was issued last cycle; its byte arrives now
    logic [7:0]        fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              accept, err_set, abort_now, read_stop, pop, strobes_done;
    logic [2:0]        occ_after;

    assign pop          = (fifo_cnt != 2'd0) && out_ready;
    assign strobes_done = (byte_cnt == 7'(BLK_BYTES));
    // Slots taken once this cycle's pop is gone; a new strobe needs one of the two left free.
    assign occ_after    = 3'(fifo_cnt) + 3'(pend) - 3'(pop);

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE);

    always_comb begin
        case (op)
            OP_KEY:   load_last_idx = 7'(KEY_BYTES - 1);
            OP_NONCE: load_last_idx = 7'(NONCE_BYTES - 1);
            default:  load_last_idx = 7'(CTR_BYTES - 1);
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next    = state;
        cmd_ready     = 1'b0;
        in_ready      = 1'b0;
        chip_hold     = 1'b0;
        chip_rd_blk   = 1'b0;
        chip_wr_key   = 1'b0;
        chip_wr_nnc   = 1'b0;
        chip_wr_ctr   = 1'b0;
        chip_data_out = 8'd0;
        accept        = 1'b0;
        err_set       = 1'b0;
        abort_now     = 1'b0;
        read_stop     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (cmd_op == OP_READ) ? WAIT : LOAD;
                end
            end
            LOAD: begin
                in_ready  = 1'b1;
                chip_hold = 1'b1;
                if (in_valid) begin
                    chip_data_out = in_data;
                    chip_wr_key   = (op == OP_KEY);
                    chip_wr_nnc   = (op == OP_NONCE);
                    chip_wr_ctr   = (op == OP_CTR);
                    if (byte_cnt == load_last_idx) state_next = IDLE;
                end
            end
            WAIT: begin
                if (chip_blk_ready) begin
                    state_next = READ;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            READ: begin
                abort_now   = !aborted && !strobes_done && !chip_blk_ready;
                read_stop   = aborted || abort_now || strobes_done;
                err_set     = abort_now;
                chip_rd_blk = !read_stop && (occ_after < 3'd2);
                if (read_stop && !pend && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_KEY;
            byte_cnt    <= 7'd0;
            wait_cnt    <= '0;
            err         <= 1'b0;
            aborted     <= 1'b0;
            pend        <= 1'b0;
            // NOTE: the two skid entries are real state and are cleared, so out_data reads 0 after reset.
            fifo_mem[0] <= 8'd0;
            fifo_mem[1] <= 8'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            state <= state_next;
            pend  <= chip_rd_blk;
            if (accept) begin
                op       <= cmd_op;
                byte_cnt <= 7'd0;
                wait_cnt <= '0;
                aborted  <= 1'b0;
                err      <= 1'b0;
            end else begin
                if ((state == LOAD && in_valid) || chip_rd_blk) byte_cnt <= byte_cnt + 7'd1;
                if (state == WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
                if (abort_now) aborted <= 1'b1;
                if (err_set) err <= 1'b1;
            end
            if (pend) begin
                fifo_mem[wr_ptr] <= chip_data_in;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(pend) - 2'(pop);
        end
    end

`ifdef CHACHA_HOST_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            blk_count <= 32'd0;
        else if (accept && cmd_op == OP_CTR)
            blk_count <= 32'd0;
        else if (state == READ && state_next == IDLE && strobes_done)
            blk_count <= blk_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_chacha_host_driver.sv
// Directed bench for chacha_host_driver: loads, block reads with backpressure, timeout, abort and reset.
module tb_chacha_host_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        busy, err;
    logic [7:0]  chip_data_out;
    logic        chip_wr_key, chip_wr_nnc, chip_wr_ctr, chip_rd_blk, chip_hold;
    logic        chip_blk_ready;
    logic [7:0]  chip_data_in = 8'd0;
    logic [7:0]  chip_idx = 8'd0;
`ifdef CHACHA_HOST_BLKCNT_EN
    logic [31:0] blk_count;
`endif

    int checks = 0;
    int errors = 0;

    chacha_host_driver dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err),
`ifdef CHACHA_HOST_BLKCNT_EN
        .blk_count(blk_count),
`endif
        .chip_data_out(chip_data_out), .chip_wr_key(chip_wr_key), .chip_wr_nnc(chip_wr_nnc),
        .chip_wr_ctr(chip_wr_ctr), .chip_rd_blk(chip_rd_blk), .chip_hold(chip_hold),
        .chip_blk_ready(chip_blk_ready), .chip_data_in(chip_data_in)
    );

    always #5 clk = ~clk;

    // Chip responder: byte i of a block reads back as i ^ 0xA5 one cycle after its strobe.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            chip_idx <= 8'd0;
        end else if (chip_rd_blk) begin
            chip_data_in <= chip_idx ^ 8'hA5;
            chip_idx     <= chip_idx + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers one command at a negedge; returns on the following negedge with cmd_valid dropped.
    task automatic send_cmd(input logic [1:0] op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic load_run(input logic [1:0] op, input int n_bytes, input bit gaps,
                            output int pulses, output int bad, output int hold_n, output int rdy_n);
        int sent;
        pulses = 0; bad = 0; hold_n = 0; rdy_n = 0; sent = 0;
        send_cmd(op);
        for (int i = 0; i < 2 * n_bytes && sent < n_bytes; i++) begin
            in_valid = !gaps || (i % 2 == 0);
            in_data  = 8'(8'h40 * op + sent);
            #1;
            if (chip_wr_key || chip_wr_nnc || chip_wr_ctr) pulses++;
            if ((op == 2'd0 ? chip_wr_key : op == 2'd1 ? chip_wr_nnc : chip_wr_ctr) !== in_valid) bad++;
            if ((chip_wr_key + chip_wr_nnc + chip_wr_ctr) > 1) bad++;
            if (in_valid && chip_data_out !== in_data) bad++;
            if (chip_hold) hold_n++;
            if (cmd_ready) rdy_n++;
            if (in_valid) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
    endtask

    task automatic read_block(input bit toggle, input int drop_after,
                              output int n_out, output int n_bad, output int n_strobe,
                              output int max_out, output int hold_n,
                              output bit busy_at_last, output bit err_at_start);
        n_out = 0; n_bad = 0; n_strobe = 0; max_out = 0; hold_n = 0; busy_at_last = 1'b0;
        chip_blk_ready = 1'b1;
        send_cmd(2'd3);
        err_at_start = err;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = !toggle || (cyc % 2 == 0);
            if (drop_after > 0 && n_strobe >= drop_after) chip_blk_ready = 1'b0;
            #1;
            if (chip_rd_blk) n_strobe++;
            if (chip_hold) hold_n++;
            if (out_valid && out_ready) begin
                if (out_data !== (8'(n_out) ^ 8'hA5)) n_bad++;
                n_out++;
                busy_at_last = busy;
            end
            if (n_strobe - n_out > max_out) max_out = n_strobe - n_out;
            if (!busy) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int  pulses, bad, hold_n, rdy_n;
        int  n_out, n_bad, n_strobe, max_out;
        bit  busy_at_last, err_at_start;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; in_valid = 1'b0; in_data = 8'd0;
        out_ready = 1'b0; chip_blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", {cmd_ready, in_ready, out_valid, busy, err, chip_wr_key, chip_wr_nnc,
                            chip_wr_ctr, chip_rd_blk, chip_hold}, 10'h200);
        check("reset_data", {out_data, chip_data_out}, 16'h0000);
`ifdef CHACHA_HOST_BLKCNT_EN
        check("reset_blk_count", blk_count, 32'd0);
`endif
        rst = 1'b0;

        load_run(2'd0, 32, 1'b0, pulses, bad, hold_n, rdy_n);
        check("key_pulses", pulses, 32);
        check("key_strobe_data", bad, 0);
        check("key_hold_cycles", hold_n, 32);
        check("key_done", {busy, chip_hold, cmd_ready}, 3'b001);

        load_run(2'd1, 8, 1'b1, pulses, bad, hold_n, rdy_n);
        check("nonce_pulses", pulses, 8);
        check("nonce_strobe_data", bad, 0);
        check("nonce_cmd_ready_busy", rdy_n, 0);
        check("nonce_done", {busy, chip_hold, cmd_ready}, 3'b001);

        load_run(2'd2, 8, 1'b0, pulses, bad, hold_n, rdy_n);
        check("ctr_pulses", pulses, 8);
        check("ctr_strobe_data", bad, 0);
        check("ctr_hold_cycles", hold_n, 8);

        read_block(1'b0, 0, n_out, n_bad, n_strobe, max_out, hold_n, busy_at_last, err_at_start);
        check("rd1_bytes", n_out, 64);
        check("rd1_data", n_bad, 0);
        check("rd1_strobes", n_strobe, 64);
        check("rd1_hold", hold_n, 0);
        check("rd1_busy_last_pop", busy_at_last, 1'b1);
        check("rd1_end", {busy, err, out_valid}, 3'b000);
        check("rd1_outstanding_le2", max_out <= 2, 1'b1);

        read_block(1'b1, 0, n_out, n_bad, n_strobe, max_out, hold_n, busy_at_last, err_at_start);
        check("rd2_bytes", n_out, 64);
        check("rd2_data", n_bad, 0);
        check("rd2_strobes", n_strobe, 64);
        check("rd2_outstanding_le2", max_out <= 2, 1'b1);
        check("rd2_end", {busy, err}, 2'b00);
`ifdef CHACHA_HOST_BLKCNT_EN
        check("blk_count_two", blk_count, 32'd2);
`endif

        chip_blk_ready = 1'b0;
        send_cmd(2'd3);
        repeat (4095) @(negedge clk);
        #1;
        check("timeout_before", {err, busy}, 2'b01);
        @(negedge clk);
        #1;
        check("timeout_after", {err, busy, cmd_ready}, 3'b101);

        read_block(1'b0, 10, n_out, n_bad, n_strobe, max_out, hold_n, busy_at_last, err_at_start);
        check("err_cleared_by_cmd", err_at_start, 1'b0);
        check("abort_bytes", n_out, 10);
        check("abort_strobes", n_strobe, 10);
        check("abort_data", n_bad, 0);
        check("abort_end", {busy, err}, 2'b01);
`ifdef CHACHA_HOST_BLKCNT_EN
        check("blk_count_no_abort", blk_count, 32'd2);
`endif

        send_cmd(2'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
        end
        #1;
        check("mid_load_state", {busy, chip_hold, err}, 3'b110);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ctl", {cmd_ready, in_ready, out_valid, busy, err, chip_wr_key, chip_wr_nnc,
                          chip_wr_ctr, chip_rd_blk, chip_hold}, 10'h200);
        check("rst_data", {out_data, chip_data_out}, 16'h0000);
`ifdef CHACHA_HOST_BLKCNT_EN
        check("rst_blk_count", blk_count, 32'd0);
`endif
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
